// File: rtl/switch_poll_master.sv
// Avalon-MM read master: polls a 1-bit switch PIO, debounces it, reports level + change pulse.
// Sample lands 1+READ_LATENCY edges after REQ entry; avm_read is held through waitrequest stalls.
module switch_poll_master #(
   parameter int         POLL_PERIOD    = 50000,
   parameter int         DEBOUNCE_COUNT = 4,
   parameter int         READ_LATENCY   = 1,
   parameter logic [1:0] SLAVE_ADDR     = 2'd0
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        enable,
   output logic [1:0]  avm_address,
   output logic        avm_read,
   input  logic        avm_waitrequest,
   input  logic [31:0] avm_readdata,
   output logic        switch_state,
   output logic        switch_changed,
   output logic        raw_sample,
   output logic [15:0] sample_count
);

   localparam int             TW           = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
   localparam logic [TW-1:0]  TIMER_RELOAD = TW'(POLL_PERIOD - 1);
   localparam logic [1:0]     LAT_RELOAD   = 2'(READ_LATENCY - 1);
   localparam logic [4:0]     DB_LIMIT     = 5'(DEBOUNCE_COUNT);

   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

   state_t          state;
   logic [TW-1:0]   timer;
   logic [1:0]      lat_cnt;
   logic [3:0]      db_cnt;
   logic            sample_bit;
   logic            unused_readdata;

   assign avm_address     = SLAVE_ADDR;
   assign sample_bit      = avm_readdata[0];
   assign unused_readdata = ^avm_readdata[31:1];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state          <= IDLE;
         timer          <= '0;
         lat_cnt        <= '0;
         db_cnt         <= '0;
         avm_read       <= 1'b0;
         switch_state   <= 1'b0;
         switch_changed <= 1'b0;
         raw_sample     <= 1'b0;
         sample_count   <= '0;
      end else begin
         switch_changed <= 1'b0;
         case (state)
            IDLE: begin
               if (timer != '0) begin
                  timer <= timer - 1'b1;
               end else if (enable) begin
                  state    <= REQ;
                  avm_read <= 1'b1;
               end
            end
            REQ: begin
               if (!avm_waitrequest) begin
                  state    <= WAIT;
                  avm_read <= 1'b0;
                  lat_cnt  <= LAT_RELOAD;
               end
            end
            WAIT: begin
               if (lat_cnt != '0) begin
                  lat_cnt <= lat_cnt - 1'b1;
               end else begin
                  // Sample edge: readdata is valid now.
                  state        <= IDLE;
                  timer        <= TIMER_RELOAD;
                  raw_sample   <= sample_bit;
                  sample_count <= sample_count + 16'd1;
                  if (sample_bit == switch_state) begin
                     db_cnt <= '0;
                  end else if ({1'b0, db_cnt} + 5'd1 == DB_LIMIT) begin
                     switch_state   <= sample_bit;
                     switch_changed <= 1'b1;
                     db_cnt         <= '0;
                  end else begin
                     db_cnt <= db_cnt + 4'd1;
                  end
               end
            end
            default: begin
               state    <= IDLE;
               avm_read <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_switch_poll_master.sv
// Directed bench for switch_poll_master with POLL_PERIOD=8, DEBOUNCE_COUNT=4, READ_LATENCY=1.
module tb_switch_poll_master;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        enable;
   logic [1:0]  avm_address;
   logic        avm_read;
   logic        avm_waitrequest;
   logic [31:0] avm_readdata;
   logic        switch_state;
   logic        switch_changed;
   logic        raw_sample;
   logic [15:0] sample_count;

   int passed = 0;
   int total  = 0;
   int gap;
   int highs;
   int pulse_rises = 0;
   int pulse_highs = 0;
   logic prev_changed = 1'b0;

   switch_poll_master #(
      .POLL_PERIOD(8), .DEBOUNCE_COUNT(4), .READ_LATENCY(1), .SLAVE_ADDR(2'd0)
   ) dut (
      .clk(clk), .reset_n(reset_n), .enable(enable),
      .avm_address(avm_address), .avm_read(avm_read),
      .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
      .switch_state(switch_state), .switch_changed(switch_changed),
      .raw_sample(raw_sample), .sample_count(sample_count)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   always @(negedge clk) begin
      if (switch_changed) pulse_highs++;
      if (switch_changed && !prev_changed) pulse_rises++;
      prev_changed = switch_changed;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Negedges until avm_read is seen rising; -1 when the bound expires.
   task automatic wait_rise(output int n);
      logic last;
      last = avm_read;
      n = -1;
      for (int i = 1; i <= 200; i++) begin
         @(negedge clk);
         if (!last && avm_read) begin
            n = i;
            break;
         end
         last = avm_read;
      end
   endtask

   // Waits for the next read, drives its data, and returns just after its sample edge.
   task automatic poll(input logic d, output int n);
      wait_rise(n);
      avm_readdata = {31'd0, d};
      @(negedge clk);
      @(negedge clk);
   endtask

   initial begin
      reset_n = 1'b0;
      enable = 1'b1;
      avm_waitrequest = 1'b0;
      avm_readdata = '0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_read", {31'd0, avm_read}, 0);
      chk("rst_addr", {30'd0, avm_address}, 0);
      chk("rst_state", {31'd0, switch_state}, 0);
      chk("rst_changed", {31'd0, switch_changed}, 0);
      chk("rst_raw", {31'd0, raw_sample}, 0);
      chk("rst_count", {16'd0, sample_count}, 0);

      // Steady 0 input: first read immediate, then one every 10 cycles.
      reset_n = 1'b1;
      wait_rise(gap);
      chk("first_read_gap", gap, 1);
      @(negedge clk);
      chk("read_drops_after_accept", {31'd0, avm_read}, 0);
      chk("count_before_sample", {16'd0, sample_count}, 0);
      @(negedge clk);
      chk("count_first_sample", {16'd0, sample_count}, 1);
      for (int i = 0; i < 3; i++) begin
         poll(1'b0, gap);
         // 10-cycle interval minus the 2 negedges already consumed by the previous poll.
         chk("steady_gap", gap, 8);
         chk("steady_count", {16'd0, sample_count}, 32'(2 + i));
         chk("steady_state", {31'd0, switch_state}, 0);
      end

      // Input goes 0->1: state rises on the 4th sample.
      poll(1'b1, gap);
      chk("rise_raw1", {31'd0, raw_sample}, 1);
      chk("rise_state1", {31'd0, switch_state}, 0);
      poll(1'b1, gap);
      poll(1'b1, gap);
      chk("rise_state3", {31'd0, switch_state}, 0);
      poll(1'b1, gap);
      chk("rise_state4", {31'd0, switch_state}, 1);
      chk("rise_pulse", {31'd0, switch_changed}, 1);
      chk("rise_count", {16'd0, sample_count}, 8);
      @(negedge clk);
      chk("rise_pulse_clear", {31'd0, switch_changed}, 0);

      // Bounce while high: 0,0,1,0,0,0,0 -> only the 7th sample flips state.
      poll(1'b0, gap);
      poll(1'b0, gap);
      poll(1'b1, gap);
      chk("bounce_raw", {31'd0, raw_sample}, 1);
      poll(1'b0, gap);
      poll(1'b0, gap);
      poll(1'b0, gap);
      chk("bounce_state6", {31'd0, switch_state}, 1);
      poll(1'b0, gap);
      chk("bounce_state7", {31'd0, switch_state}, 0);
      chk("bounce_pulse", {31'd0, switch_changed}, 1);
      chk("bounce_count", {16'd0, sample_count}, 15);

      // Waitrequest high for 3 cycles.
      wait_rise(gap);
      avm_readdata = '0;
      avm_waitrequest = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stall_read", {31'd0, avm_read}, 1);
         chk("stall_addr", {30'd0, avm_address}, 0);
      end
      avm_waitrequest = 1'b0;
      @(negedge clk);
      chk("stall_accepted", {31'd0, avm_read}, 0);
      chk("stall_count_pre", {16'd0, sample_count}, 15);
      @(negedge clk);
      chk("stall_count_post", {16'd0, sample_count}, 16);
      wait_rise(gap);
      // Interval 13 from read start, 5 negedges already consumed.
      chk("stall_gap", gap, 8);

      // Enable dropped right after REQ entry.
      enable = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("disable_sampled", {16'd0, sample_count}, 17);
      highs = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (avm_read) highs++;
      end
      chk("disable_no_read", highs, 0);
      enable = 1'b1;
      wait_rise(gap);
      chk("reenable_gap", gap, 1);
      @(negedge clk);
      @(negedge clk);
      chk("reenable_count", {16'd0, sample_count}, 18);

      // Drive state to 1, then reset during WAIT.
      for (int i = 0; i < 4; i++) poll(1'b1, gap);
      chk("pre_reset_state", {31'd0, switch_state}, 1);
      wait_rise(gap);
      avm_readdata = 32'd1;
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      chk("async_rst_read", {31'd0, avm_read}, 0);
      chk("async_rst_state", {31'd0, switch_state}, 0);
      chk("async_rst_raw", {31'd0, raw_sample}, 0);
      chk("async_rst_count", {16'd0, sample_count}, 0);
      @(negedge clk);
      reset_n = 1'b1;
      wait_rise(gap);
      chk("post_rst_gap", gap, 1);
      @(negedge clk);
      @(negedge clk);
      chk("post_rst_raw", {31'd0, raw_sample}, 1);
      chk("post_rst_state1", {31'd0, switch_state}, 0);
      poll(1'b1, gap);
      poll(1'b1, gap);
      chk("post_rst_state3", {31'd0, switch_state}, 0);
      poll(1'b1, gap);
      chk("post_rst_state4", {31'd0, switch_state}, 1);
      chk("post_rst_count", {16'd0, sample_count}, 4);

      @(negedge clk);
      chk("pulse_rises", pulse_rises, 4);
      chk("pulse_width", pulse_highs, 4);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
